input_buffer_loader: RTL and testbench
======================================

# input_buffer_loader

Streaming loader that feeds the 4-MLB input buffer. It accepts 32-bit activation words from a valid/ready source and packs them 16 at a time into lane vectors. Each vector becomes one write beat toward the input buffer, carrying select_in, select_mlb, sub_tile_idx, unit_tile_idx and write_en. It sits between the DMA/stream front-end and the input buffer, and is the write-side counterpart to that buffer.

## Interface
Parameters:
- DATA_W, 32, word width
- LANES, 16, words per write beat (one MLB width)
- NUM_MLB, 4, MLBs addressed by ib_select_mlb
- NUM_UNIT, 8, unit tiles per sub tile
- NUM_SUB, 4, maximum sub tiles per tile

Ports (clock, reset, then the remaining ports):
- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a tile load when idle
- cfg_sub_tiles  in  3  sub tiles to load (1..4); latched on start; 0 means 4; values above 4 are clamped to 4
- s_data  in  DATA_W  stream word
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts s_data this cycle
- ib_select_in  out  DATA_W x LANES  unpacked lane array; lane 0 is the first word received
- ib_select_mlb  out  2  target MLB
- ib_sub_tile_idx  out  2  sub-tile index
- ib_unit_tile_idx  out  3  unit-tile index
- ib_write_en  out  1  write strobe to the input buffer
- busy  out  1  high from the accepted start until DONE completes
- done  out  1  one-cycle pulse after the last write

## Operation
- FSM states: IDLE, FILL, SETUP, WRITE, DONE.
- IDLE:
  - start=1 → latch cfg_sub_tiles, clear all counters, go to FILL.
  - start is ignored in every other state.
- FILL:
  - s_ready=1.
  - Each handshake (s_valid && s_ready) stores s_data at lane[lane_cnt] of an internal pack register and increments lane_cnt.
  - On the 16th handshake → SETUP.
  - s_valid=0 cycles stall with no state change.
- SETUP:
  - s_ready=0.
  - Pack register is copied to ib_select_in; the current mlb/sub/unit counters drive the index outputs.
  - ib_write_en=0.
  - Purpose: the input buffer registers select_in one edge before the MLB write.
- WRITE:
  - ib_write_en=1 for exactly one cycle; all ib_* outputs are stable.
  - Counters then advance: unit_tile_idx innermost (0..7), then select_mlb (0..3), then sub_tile_idx (0..cfg-1).
  - If the last beat was written → DONE, otherwise → FILL with lane_cnt=0.
- DONE: done=1 and busy=1 for one cycle, then → IDLE.
- Beat count: one beat is 16 words; the total is 32×cfg_sub_tiles beats (cfg=4 → 128 beats, 2048 words).
- ib_select_in and the index outputs hold their last value until the next SETUP; they are not cleared in IDLE.
- Counters wrap only by FSM control; no modular overflow is used as a terminal condition.

## Timing
- Reset values: s_ready=0, ib_write_en=0, busy=0, done=0, ib_select_mlb=0, ib_sub_tile_idx=0, ib_unit_tile_idx=0, all ib_select_in lanes=0. FSM resets to IDLE and all counters to 0.
- Reset asserted mid-operation aborts immediately:
  - partial pack data is discarded;
  - no ib_write_en and no done pulse is issued.
- start at cycle t → FILL at t+1, where s_ready=1.
- With continuous s_valid, one beat takes 18 cycles: 16 FILL, 1 SETUP, 1 WRITE.
  - s_ready is low for exactly 2 cycles per beat.
- The last WRITE is at cycle w; done=1 at w+1; busy falls and the FSM is in IDLE at w+2.
- busy rises the cycle after start is accepted.
- s_valid while s_ready=0 is not consumed; the source must hold the word.

## Test plan
- Reset: assert rst for 3 cycles with random inputs → every output at its reset value; s_ready=0 throughout.
- cfg_sub_tiles=1, words 0..511 with continuous valid → 32 write beats.
  - Beat 0: mlb=0, unit=0, sub=0, lanes 0..15.
  - Beat 8: mlb=1, unit=0, lanes 128..143.
  - Beat 31: mlb=3, unit=7, lanes 496..511.
  - done pulses once, 1 cycle after the last ib_write_en.
- Same load with s_valid toggling 1/0 → identical beat contents; each beat is 34 cycles; no word lost or duplicated.
- cfg_sub_tiles=0, 2048 words → 128 beats; sub_tile_idx goes 0..3; last beat is sub=3, mlb=3, unit=7, holding words 2032..2047.
- start pulsed during FILL, SETUP and WRITE → ignored; counters and beat sequence unchanged.
- Reset after 7 words of beat 5 → no write and no done; a new start with cfg=1 plus fresh words 0..511 reproduces the beat 0 result of the second scenario.

Source files
------------

// File: rtl/input_buffer_loader.sv
// input_buffer_loader
// Packs 32-bit stream words sixteen at a time into lane vectors and emits one
// write beat per vector toward the 4-MLB input buffer. The beat order is
// unit tile (innermost), then MLB, then sub tile.
//
// Handshake: a stream word transfers on a rising clk edge where both s_valid
// and s_ready are high. s_ready is registered and never depends on s_valid in
// the same cycle. A word offered while s_ready is low is not consumed, so the
// source must hold s_data/s_valid until the transfer happens.
module input_buffer_loader #(
    parameter int DATA_W   = 32,
    parameter int LANES    = 16,
    parameter int NUM_MLB  = 4,
    parameter int NUM_UNIT = 8,
    parameter int NUM_SUB  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        cfg_sub_tiles,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] ib_select_in [LANES],
    output logic [1:0]        ib_select_mlb,
    output logic [1:0]        ib_sub_tile_idx,
    output logic [2:0]        ib_unit_tile_idx,
    output logic              ib_write_en,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    localparam int LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
    localparam logic [2:0]        UNIT_LAST = 3'(NUM_UNIT - 1);
    localparam logic [1:0]        MLB_LAST  = 2'(NUM_MLB - 1);
    localparam logic [1:0]        SUB_MAX   = 2'(NUM_SUB - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SETUP = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   pack [LANES];
    logic [LANE_W-1:0]   lane_cnt;
    logic [2:0]          unit_cnt;
    logic [1:0]          mlb_cnt;
    logic [1:0]          sub_cnt;
    logic [1:0]          sub_last;
    logic                last_beat;

    assign dbg_state = state;

    // Final beat of the tile: every counter sits at its terminal value.
    assign last_beat = (unit_cnt == UNIT_LAST) && (mlb_cnt == MLB_LAST) &&
                       (sub_cnt == sub_last);

    // Loader FSM: packing, beat presentation, index sequencing and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            lane_cnt         <= '0;
            unit_cnt         <= '0;
            mlb_cnt          <= '0;
            sub_cnt          <= '0;
            sub_last         <= '0;
            s_ready          <= 1'b0;
            ib_write_en      <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            ib_select_mlb    <= '0;
            ib_sub_tile_idx  <= '0;
            ib_unit_tile_idx <= '0;
            for (int i = 0; i < LANES; i++) begin
                pack[i]         <= '0;
                ib_select_in[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // 0 and anything above the sub-tile count mean a full tile.
                        if (cfg_sub_tiles == 3'd0 || cfg_sub_tiles > 3'(NUM_SUB))
                            sub_last <= SUB_MAX;
                        else
                            sub_last <= 2'(cfg_sub_tiles - 3'd1);
                        lane_cnt <= '0;
                        unit_cnt <= '0;
                        mlb_cnt  <= '0;
                        sub_cnt  <= '0;
                        busy     <= 1'b1;
                        s_ready  <= 1'b1;
                        state    <= FILL;
                    end
                end

                FILL: begin
                    if (s_valid && s_ready) begin
                        pack[lane_cnt] <= s_data;
                        if (lane_cnt == LANE_LAST) begin
                            // Present the completed vector while in SETUP so the
                            // input buffer can register it one edge ahead of the
                            // write strobe. The last lane bypasses the pack
                            // register because it arrives on this same edge.
                            for (int i = 0; i < LANES; i++)
                                ib_select_in[i] <= (i == LANES - 1) ? s_data : pack[i];
                            ib_select_mlb    <= mlb_cnt;
                            ib_sub_tile_idx  <= sub_cnt;
                            ib_unit_tile_idx <= unit_cnt;
                            lane_cnt         <= '0;
                            s_ready          <= 1'b0;
                            state            <= SETUP;
                        end else begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end

                SETUP: begin
                    ib_write_en <= 1'b1;
                    state       <= WRITE;
                end

                WRITE: begin
                    ib_write_en <= 1'b0;
                    if (last_beat) begin
                        unit_cnt <= '0;
                        mlb_cnt  <= '0;
                        sub_cnt  <= '0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        if (unit_cnt == UNIT_LAST) begin
                            unit_cnt <= '0;
                            if (mlb_cnt == MLB_LAST) begin
                                mlb_cnt <= '0;
                                sub_cnt <= sub_cnt + 1'b1;
                            end else begin
                                mlb_cnt <= mlb_cnt + 1'b1;
                            end
                        end else begin
                            unit_cnt <= unit_cnt + 1'b1;
                        end
                        s_ready <= 1'b1;
                        state   <= FILL;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    s_ready     <= 1'b0;
                    ib_write_en <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_buffer_loader.sv
// Bench for input_buffer_loader: expected beats are queued as each load is
// launched and compared, in order, whenever the loader raises ib_write_en.
module tb_input_buffer_loader;

    localparam int DATA_W = 32;
    localparam int LANES  = 16;
    localparam int BEAT_W = DATA_W * LANES + 7;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        cfg_sub_tiles;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] ib_select_in [LANES];
    logic [1:0]        ib_select_mlb;
    logic [1:0]        ib_sub_tile_idx;
    logic [2:0]        ib_unit_tile_idx;
    logic              ib_write_en;
    logic              busy;
    logic              done;
    logic [2:0]        dbg_state;

    always #5 clk = ~clk;

    input_buffer_loader dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cfg_sub_tiles    (cfg_sub_tiles),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .ib_select_in     (ib_select_in),
        .ib_select_mlb    (ib_select_mlb),
        .ib_sub_tile_idx  (ib_sub_tile_idx),
        .ib_unit_tile_idx (ib_unit_tile_idx),
        .ib_write_en      (ib_write_en),
        .busy             (busy),
        .done             (done),
        .dbg_state        (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [BEAT_W-1:0] exp_q [$];
    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_wr  = -1000;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int exp_gap  = 18;

    task automatic chk(input string tag, input logic [BEAT_W-1:0] got,
                       input logic [BEAT_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat b of a load whose first word is base: unit innermost, then MLB, then sub.
    function automatic logic [BEAT_W-1:0] mk_beat(input logic [31:0] base, input int b);
        logic [BEAT_W-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++)
            v[l*DATA_W +: DATA_W] = base + 32'(b * LANES + l);
        v[LANES*DATA_W +: 3]     = 3'(b % 8);
        v[LANES*DATA_W + 3 +: 2] = 2'((b / 8) % 4);
        v[LANES*DATA_W + 5 +: 2] = 2'(b / 32);
        return v;
    endfunction

    function automatic logic [BEAT_W-1:0] observe();
        logic [BEAT_W-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++)
            v[l*DATA_W +: DATA_W] = ib_select_in[l];
        v[LANES*DATA_W +: 3]     = ib_unit_tile_idx;
        v[LANES*DATA_W + 3 +: 2] = ib_select_mlb;
        v[LANES*DATA_W + 5 +: 2] = ib_sub_tile_idx;
        return v;
    endfunction

    // Output monitor: pops one expected beat per write strobe.
    task automatic monitor();
        logic [BEAT_W-1:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (ib_write_en) begin
                wr_cnt++;
                if (cyc - last_wr < 60)
                    chk("beat_gap", cyc - last_wr, exp_gap);
                chk("busy_in_write", busy, 1);
                chk("pending_beats", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("beat", observe(), e);
                end
                last_wr = cyc;
            end
            if (done) begin
                done_cnt++;
                chk("done_after_write", cyc - last_wr, 1);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [2:0] cfg);
        @(posedge clk); #1;
        cfg_sub_tiles = cfg;
        start = 1'b1;
        @(negedge clk);
        chk("busy_before_accept", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        cfg_sub_tiles = 3'($urandom_range(0, 7));
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("ready_in_fill", s_ready, 1);
        chk("state_fill", dbg_state, 1);
    endtask

    task automatic send_words(input logic [31:0] base, input int n, input bit toggle);
        int i = 0;
        int guard = 0;
        bit ph = 1'b1;
        while (i < n && guard < 4 * n + 200) begin
            @(posedge clk); #1;
            s_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            s_data = base + 32'(i);
            @(negedge clk);
            if (s_valid && s_ready) i++;
            guard++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("words_accepted", i, n);
    endtask

    task automatic start_glitch();
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        repeat (40) @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < bound);
        chk("done_seen", done, 1);
    endtask

    task automatic run_load(input logic [2:0] cfg, input logic [31:0] base,
                            input bit toggle, input bit glitch);
        int nsub;
        int d0;
        nsub = (cfg == 3'd0 || cfg > 3'd4) ? 4 : int'(cfg);
        for (int b = 0; b < 32 * nsub; b++)
            exp_q.push_back(mk_beat(base, b));
        exp_gap = toggle ? 34 : 18;
        d0 = done_cnt;
        do_start(cfg);
        fork
            send_words(base, 512 * nsub, toggle);
            if (glitch) start_glitch();
        join
        wait_done(60);
        @(negedge clk);
        chk("busy_low_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("state_idle", dbg_state, 0);
        chk("queue_drained", exp_q.size(), 0);
        repeat (60) @(negedge clk);
        chk("done_pulse_count", done_cnt - d0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w0;
        int d0;
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        cfg_sub_tiles = '0;
        fork
            monitor();
        join_none

        // Reset with random inputs.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            start = 1'($urandom_range(0, 1));
            s_valid = 1'($urandom_range(0, 1));
            s_data = $urandom;
            cfg_sub_tiles = 3'($urandom_range(0, 7));
            @(negedge clk);
            chk("reset_s_ready", s_ready, 0);
        end
        chk("reset_beat", observe(), 0);
        chk("reset_write_en", ib_write_en, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_state", dbg_state, 0);
        @(posedge clk); #1;
        start = 1'b0;
        s_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_load(3'd1, 32'd0, 1'b0, 1'b0);
        run_load(3'd1, 32'd0, 1'b1, 1'b0);
        run_load(3'd2, $urandom, 1'b0, 1'b1);
        run_load(3'd0, 32'd0, 1'b0, 1'b0);
        run_load(3'd5, $urandom, 1'b0, 1'b0);

        // Abort mid-beat: 5 full beats plus 7 words of beat 5.
        for (int b = 0; b < 5; b++)
            exp_q.push_back(mk_beat(32'd0, b));
        exp_gap = 18;
        do_start(3'd1);
        send_words(32'd0, 5 * 16 + 7, 1'b0);
        w0 = wr_cnt;
        d0 = done_cnt;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_state", dbg_state, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("abort_no_write", wr_cnt - w0, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_queue", exp_q.size(), 0);

        run_load(3'd1, 32'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
